// File: rtl/mmio_timer_if.sv
// mmio_timer_if: data-memory bus between the core (master) and a memory-mapped
// peripheral (slave). All signals are sampled on the peripheral's clock.
//   addr  : byte address, master -> slave
//   re    : read strobe, master -> slave
//   wr    : write strobe, master -> slave
//   wdata : write data, master -> slave
//   rdata : read data, slave -> master (combinational in the slave)
interface mmio_timer_if #(
    parameter int unsigned BusWidth = 32
);
    logic [BusWidth-1:0] addr;
    logic                re;
    logic                wr;
    logic [BusWidth-1:0] wdata;
    logic [BusWidth-1:0] rdata;

    modport master (
        output addr,
        output re,
        output wr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  re,
        input  wr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer/compare peripheral on the core's
// data-memory bus. A 16-bit prescaler divides the clock into ticks; each tick
// advances COUNT, and COUNT == COMPARE on a tick sets the sticky MATCH flag
// (optionally reloading COUNT to 0).
//
// Ports:
//   clk_i   : clock, all state changes on the rising edge
//   reset_i : synchronous active-high reset
//   bus_io  : slave end of the data-memory bus (addr, re, wr, wdata, rdata)
//   irq_o   : level interrupt, MATCH & IRQ_EN
//
// Register map (word index addr[4:2] inside a 32-byte window at BaseAddr):
//   0 CTRL {IRQ_EN, AUTO_RELOAD, EN}, 1 PRESCALE[15:0], 2 COUNT, 3 COMPARE,
//   4 STATUS {MATCH} write-1-to-clear, 5-7 read 0.
//
// Build option: define MMIO_TIMER_IRQ_EN to implement CTRL.IRQ_EN and drive
// irq_o. Without it CTRL bit2 reads 0 and irq_o is tied 0.
module mmio_timer #(
    parameter int unsigned BusWidth = 32,
    parameter logic [31:0] BaseAddr = 32'h0000_1000
) (
    input  logic         clk_i,
    input  logic         reset_i,
    mmio_timer_if.slave  bus_io,
    output logic         irq_o
);
    localparam logic [2:0] IdxCtrl     = 3'd0;
    localparam logic [2:0] IdxPrescale = 3'd1;
    localparam logic [2:0] IdxCount    = 3'd2;
    localparam logic [2:0] IdxCompare  = 3'd3;
    localparam logic [2:0] IdxStatus   = 3'd4;

    logic                hit;
    logic [2:0]          idx;
    logic                wr_hit;
    logic                tick;
    logic                cmp_eq;

    logic                en_q, auto_q;
    logic [15:0]         prescale_q, pc_q, pc_d;
    logic [BusWidth-1:0] count_q, count_d;
    logic [BusWidth-1:0] compare_q;
    logic                match_q, match_d;
    logic                irq_en_q;

    // Byte-lane bits are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_io.addr[1:0];

    assign hit    = (bus_io.addr[31:5] == BaseAddr[31:5]);
    assign idx    = bus_io.addr[4:2];
    assign wr_hit = bus_io.wr && hit;
    assign tick   = en_q && (pc_q == prescale_q);
    assign cmp_eq = (count_q == compare_q);

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        match_d = match_q;

        if (en_q) begin
            pc_d = tick ? 16'd0 : pc_q + 16'd1;
        end
        if (tick) begin
            count_d = (cmp_eq && auto_q) ? '0 : count_q + 1'b1;
        end

        if (wr_hit) begin
            unique case (idx)
                IdxPrescale: pc_d = 16'd0;
                IdxCount: begin
                    count_d = bus_io.wdata;
                    pc_d    = 16'd0;
                end
                IdxStatus: if (bus_io.wdata[0]) match_d = 1'b0;
                default: ;
            endcase
        end

        // A match on this edge beats a same-edge clear.
        if (tick && cmp_eq) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            prescale_q <= 16'd0;
            pc_q       <= 16'd0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            match_q <= match_d;
            if (wr_hit && idx == IdxCtrl) begin
                en_q   <= bus_io.wdata[0];
                auto_q <= bus_io.wdata[1];
            end
            if (wr_hit && idx == IdxPrescale) begin
                prescale_q <= bus_io.wdata[15:0];
            end
            if (wr_hit && idx == IdxCompare) begin
                compare_q <= bus_io.wdata;
            end
        end
    end

`ifdef MMIO_TIMER_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            irq_en_q <= 1'b0;
        end else if (wr_hit && idx == IdxCtrl) begin
            irq_en_q <= bus_io.wdata[2];
        end
    end
    // Both operands are flops, so the line cannot glitch on bus activity.
    assign irq_o = match_q & irq_en_q;
`else
    assign irq_en_q = 1'b0;
    assign irq_o    = 1'b0;
`endif

    always_comb begin
        bus_io.rdata = '0;
        if (bus_io.re && hit) begin
            case (idx)
                IdxCtrl:     bus_io.rdata = {{(BusWidth-3){1'b0}}, irq_en_q, auto_q, en_q};
                IdxPrescale: bus_io.rdata = {{(BusWidth-16){1'b0}}, prescale_q};
                IdxCount:    bus_io.rdata = count_q;
                IdxCompare:  bus_io.rdata = compare_q;
                IdxStatus:   bus_io.rdata = {{(BusWidth-1){1'b0}}, match_q};
                default:     bus_io.rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;
    localparam logic [31:0] Base = 32'h0000_1000;
    localparam logic [31:0] ACtrl = Base + 32'h00;
    localparam logic [31:0] APre  = Base + 32'h04;
    localparam logic [31:0] ACnt  = Base + 32'h08;
    localparam logic [31:0] ACmp  = Base + 32'h0C;
    localparam logic [31:0] ASt   = Base + 32'h10;
`ifdef MMIO_TIMER_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mmio_timer_if bus ();

    mmio_timer #(
        .BusWidth(32),
        .BaseAddr(Base)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus_io (bus),
        .irq_o  (irq)
    );

    // Behavioural reference: register file plus prescale phase.
    logic [2:0]  m_ctrl;
    logic [15:0] m_pre, m_pc;
    logic [31:0] m_cnt, m_cmp;
    logic        m_match;

    task automatic model_reset();
        m_ctrl = 0; m_pre = 0; m_pc = 0; m_cnt = 0; m_cmp = 0; m_match = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:5] != Base[31:5]) return 32'd0;
        case (a[4:2])
            3'd0: return {29'd0, m_ctrl};
            3'd1: return {16'd0, m_pre};
            3'd2: return m_cnt;
            3'd3: return m_cmp;
            3'd4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_irq();
        return IrqOn && m_match && m_ctrl[2];
    endfunction

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic        tk, hitm;
        logic [15:0] npc;
        logic [31:0] ncnt;
        logic        nmatch, matched;
        tk = m_ctrl[0] && (m_pc == m_pre);
        matched = tk && (m_cnt == m_cmp);
        npc = m_ctrl[0] ? (tk ? 16'd0 : m_pc + 16'd1) : m_pc;
        ncnt = m_cnt;
        nmatch = m_match;
        if (tk) ncnt = (matched && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
        if (matched) nmatch = 1'b1;
        hitm = (a[31:5] == Base[31:5]);
        if (w && hitm) begin
            case (a[4:2])
                3'd0: m_ctrl = IrqOn ? d[2:0] : {1'b0, d[1:0]};
                3'd1: begin m_pre = d[15:0]; npc = 0; end
                3'd2: begin ncnt = d; npc = 0; end
                3'd3: m_cmp = d;
                3'd4: if (d[0] && !matched) nmatch = 1'b0;
                default: ;
            endcase
        end
        m_pc = npc; m_cnt = ncnt; m_match = nmatch;
    endtask

    // One bus cycle: drive, sample outputs mid-cycle (with the model's
    // pre-edge expectations), then take the edge.
    task automatic step(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rv,
                        output logic [31:0] ev, output logic iv, output logic eiv);
        bus.wr = w; bus.re = r; bus.addr = a; bus.wdata = d;
        #2;
        rv = bus.rdata; iv = irq;
        ev = r ? model_read(a) : 32'd0;
        eiv = model_irq();
        @(posedge clk);
        model_step(w, a, d);
        #1;
        bus.wr = 1'b0; bus.re = 1'b0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rv, ev;
        logic iv, eiv;
        step(1'b1, 1'b0, a, d, rv, ev, iv, eiv);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.wr = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rv, ev;
        logic iv, eiv;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, Base + 32'(i * 4), 32'd0, rv, ev, iv, eiv);
            total++;
            if (rv !== 32'd0) begin
                bad++; $display("FAIL reset_read off=%0d got=%h want=%h", i * 4, rv, 32'd0);
            end
            total++;
            if (iv !== 1'b0) begin
                bad++; $display("FAIL reset_irq got=%b want=0", iv);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rv, ev;
        logic iv, eiv;
        int first;
        do_reset();
        wr_reg(APre, 0); wr_reg(ACmp, 3); wr_reg(ACnt, 0); wr_reg(ACtrl, 32'h1);
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
            if (rv === 32'd1) first = i;
        end
        total++;
        if (first != 4) begin
            bad++; $display("FAIL basic_match_time got=%0d want=4", first);
        end
        // The matching read above took edge E0+5, so COUNT is now 5, then 6.
        for (int k = 5; k <= 6; k++) begin
            step(1'b0, 1'b1, ACnt, 0, rv, ev, iv, eiv);
            total++;
            if (rv !== 32'(k)) begin
                bad++; $display("FAIL basic_count got=%0d want=%0d", rv, k);
            end
        end
    endtask

    task automatic test_prescale_reload();
        logic [31:0] rv, ev;
        logic iv, eiv;
        int first;
        do_reset();
        wr_reg(APre, 2); wr_reg(ACmp, 1); wr_reg(ACtrl, 32'h3);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, ACnt, 0, rv, ev, iv, eiv);
            total++;
            if (rv !== 32'((i / 3) % 2)) begin
                bad++; $display("FAIL reload_seq i=%0d got=%0d want=%0d", i, rv, (i / 3) % 2);
            end
        end
        do_reset();
        wr_reg(APre, 2); wr_reg(ACmp, 1); wr_reg(ACtrl, 32'h3);
        first = -1;
        for (int i = 0; i < 30 && first < 0; i++) begin
            step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
            if (rv === 32'd1) first = i;
        end
        total++;
        if (first != 6) begin
            bad++; $display("FAIL reload_match_time got=%0d want=6", first);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] rv, ev;
        logic iv, eiv;
        do_reset();
        wr_reg(APre, 0); wr_reg(ACmp, 3); wr_reg(ACnt, 0); wr_reg(ACtrl, 32'h1);
        repeat (3) step(1'b0, 1'b0, ASt, 0, rv, ev, iv, eiv);
        wr_reg(ASt, 32'h1);  // same edge as the match
        step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd1) begin
            bad++; $display("FAIL w1c_priority got=%0d want=1", rv);
        end
        wr_reg(ACmp, 1000);
        wr_reg(ASt, 32'h0);
        step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd1) begin
            bad++; $display("FAIL w1c_zero got=%0d want=1", rv);
        end
        wr_reg(ASt, 32'h1);
        step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd0) begin
            bad++; $display("FAIL w1c_clear got=%0d want=0", rv);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rv, ev;
        logic iv, eiv;
        do_reset();
        wr_reg(APre, 0); wr_reg(ACmp, 5); wr_reg(ACnt, 32'hFFFF_FFFF); wr_reg(ACtrl, 32'h1);
        step(1'b0, 1'b1, ACnt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_pre got=%h want=ffffffff", rv);
        end
        step(1'b0, 1'b1, ACnt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd0) begin
            bad++; $display("FAIL wrap_zero got=%h want=0", rv);
        end
        step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd0) begin
            bad++; $display("FAIL wrap_nomatch got=%0d want=0", rv);
        end
        wr_reg(ACnt, 7);  // every edge ticks with PRESCALE=0
        step(1'b0, 1'b1, ACnt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd7) begin
            bad++; $display("FAIL write_over_tick got=%0d want=7", rv);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rv, ev;
        logic iv, eiv;
        do_reset();
        wr_reg(ACmp, 0); wr_reg(ACtrl, 32'h5);
        step(1'b0, 1'b1, ACtrl, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== (IrqOn ? 32'h5 : 32'h1)) begin
            bad++; $display("FAIL irq_ctrl got=%h want=%h", rv, IrqOn ? 32'h5 : 32'h1);
        end
        total++;
        if (iv !== 1'b0) begin
            bad++; $display("FAIL irq_before got=%b want=0", iv);
        end
        step(1'b0, 1'b1, ASt, 0, rv, ev, iv, eiv);
        total++;
        if (rv !== 32'd1 || iv !== IrqOn) begin
            bad++; $display("FAIL irq_rise status=%0d irq=%b want 1/%b", rv, iv, IrqOn);
        end
        wr_reg(ACmp, 1000);
        step(1'b1, 1'b0, ASt, 1, rv, ev, iv, eiv);
        total++;
        if (iv !== IrqOn) begin
            bad++; $display("FAIL irq_hold got=%b want=%b", iv, IrqOn);
        end
        step(1'b0, 1'b0, ASt, 0, rv, ev, iv, eiv);
        total++;
        if (iv !== 1'b0) begin
            bad++; $display("FAIL irq_fall got=%b want=0", iv);
        end
    endtask

    task automatic test_random();
        logic [31:0] rv, ev, a, d;
        logic iv, eiv, w, r;
        do_reset();
        wr_reg(ACtrl, 32'h7);
        for (int i = 0; i < 600; i++) begin
            a = Base + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a + 32'h0000_2000;
            d = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 12));
            if (a[4:2] == 3'd1) d = 32'($urandom_range(0, 3));
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
            step(w, r, a, d, rv, ev, iv, eiv);
            total++;
            if (rv !== ev) begin
                bad++; $display("FAIL rand_rdata i=%0d addr=%h got=%h want=%h", i, a, rv, ev);
            end
            total++;
            if (iv !== eiv) begin
                bad++; $display("FAIL rand_irq i=%0d got=%b want=%b", i, iv, eiv);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.wr = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
        model_reset();
        test_reset();
        test_basic();
        test_prescale_reload();
        test_w1c();
        test_wrap();
        test_irq();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped 32-bit timer/compare peripheral that responds on the data-memory bus of the `riscv` core (`addr`, `re`, `wr`, `wdata`, `rdata`). It is the slave end of that bus. It sits beside `data_mem` and decodes its own address window. It provides a prescaled free-running counter, a compare match with a sticky status flag, optional auto-reload, and an optional interrupt line.

## Interface
- `BUS_WIDTH`, 32, data/address width; fixed at 32 for this block.
- `BASE_ADDR`, 32'h0000_1000, window base; must be 32-byte aligned; window is `BASE_ADDR` .. `BASE_ADDR+31`.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `addr` input BUS_WIDTH: byte address from core; `addr[1:0]` ignored.
- `re` input 1: read strobe.
- `wr` input 1: write strobe, sampled at rising edge.
- `wdata` input BUS_WIDTH: write data.
- `rdata` output BUS_WIDTH: read data; combinational.
- `irq` output 1: level interrupt; present only with `MMIO_TIMER_IRQ_EN`.

## Operation
- Hit: `addr[31:5] == BASE_ADDR[31:5]`. The register index is `addr[4:2]`.
- Register map:
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
  - 1 PRESCALE: bits [15:0]; upper bits read 0.
  - 2 COUNT: read/write.
  - 3 COMPARE: read/write.
  - 4 STATUS: bit0 MATCH, sticky; write-1-to-clear.
  - 5-7: read 0; writes are ignored.
- Read: `rdata` = the selected register when `re && hit`, else 0.
- Write: takes effect at the edge when `wr && hit`. No access ever stalls.
- Internal 16-bit prescale counter `pc`. When EN=1:
  - if `pc == PRESCALE`: `pc <= 0` and a tick occurs;
  - else `pc <= pc+1`.
- When EN=0, `pc` and COUNT hold.
- On a tick:
  - if COUNT == COMPARE: MATCH <= 1, and COUNT <= 0 if AUTO_RELOAD, else COUNT+1;
  - otherwise COUNT <= COUNT+1.
- Arithmetic: COUNT wraps 32'hFFFF_FFFF -> 0 with no flag. Comparison is unsigned 32-bit equality.
- Priorities, same edge:
  - a bus write to COUNT overrides a tick update;
  - a write to COUNT or PRESCALE also clears `pc`;
  - MATCH set by a tick wins over a W1C clear on the same edge.
- Writing COMPARE while running takes effect for the next tick comparison.
- STATUS write with bit0=0 has no effect.

## Timing
- Reset: all registers, `pc` and MATCH become 0. `irq` = 0; `rdata` = 0 unless `re && hit`. Reset mid-count aborts immediately with no residual tick.
- Read latency: 0 cycles (combinational). With `re` and `wr` at the same address in one cycle, `rdata` shows the pre-write value.
- Write latency: the value is visible on `rdata` the cycle after the write edge.
- Tick period: (PRESCALE+1) cycles. The first tick occurs PRESCALE+1 edges after the edge that sets EN.
- From COUNT=0 with EN set at edge E0, MATCH rises after edge E0 + (COMPARE+1)*(PRESCALE+1).
- `irq` is driven from registers, so it is glitch-free. It is asserted the same cycle MATCH is visible.

## Configuration
- `MMIO_TIMER_IRQ_EN` defined:
  - `irq` = MATCH & IRQ_EN;
  - CTRL bit2 is writable and readable.
- Not defined:
  - `irq` is tied 0;
  - CTRL bit2 is not implemented (reads 0, writes ignored);
  - all other behaviour is identical.

## Test plan
- Reset and default reads:
  - stimulus: hold `reset` 2 cycles, then read offsets 0x00-0x1C;
  - required: all reads 0, `irq`=0.
- Basic count, no auto-reload:
  - stimulus: PRESCALE=0, COMPARE=3, COUNT=0, CTRL=0x1;
  - required: MATCH=1 exactly 4 cycles after the CTRL write edge, COUNT=4 at that point, COUNT keeps incrementing.
- Prescale and auto-reload:
  - stimulus: PRESCALE=2, COMPARE=1, CTRL=0x3;
  - required: COUNT steps every 3 cycles through the sequence 0,1,0,1; MATCH first set 6 cycles after enable.
- W1C and priority:
  - stimulus: write STATUS=0x1 on the same edge a match occurs;
  - required: MATCH stays 1. A later STATUS=0x1 write clears it; a STATUS=0x0 write does nothing.
- Wrap and write priority:
  - stimulus: COUNT=32'hFFFF_FFFF, COMPARE=5, PRESCALE=0, EN=1;
  - required: the next value is 0 with no MATCH. A COUNT=7 write coinciding with a tick yields 7.
- IRQ (with macro):
  - stimulus: CTRL=0x5, COMPARE=0;
  - required: `irq` rises with MATCH, falls on the edge after W1C (COMPARE changed to avoid re-match). Without the macro, `irq` stays 0 and CTRL reads 0x1.
